sprite_line_engine: RTL

SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

---
 rtl/sprite_line_engine.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: scans the attribute table for sprites on the next
// line, then streams their pattern pixels into a line buffer.
module sprite_line_engine #(
    parameter int unsigned NUM_SPRITE = 32,
    parameter int unsigned MAX_SLOT   = 8,
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter logic [15:0] KEY_COLOR  = 16'h0000,
    localparam int unsigned IdxW      = (NUM_SPRITE > 1) ? $clog2(NUM_SPRITE) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      vcount,
    input  logic            wr_en,
    input  logic [IdxW-1:0] wr_idx,
    input  logic [31:0]     wr_data,
    output logic [15:0]     rom_addr,
    input  logic [15:0]     rom_q,
    output logic [9:0]      pixel_col,
    output logic [15:0]     pixel_data,
    output logic            pixel_wren,
    output logic            overflow,
    output logic            done
);

    localparam int unsigned XW     = $clog2(SPR_W);
    localparam int unsigned YW     = $clog2(SPR_H);
    localparam int unsigned CntW   = $clog2(NUM_SPRITE + 1);
    localparam int unsigned SlotW  = $clog2(MAX_SLOT + 1);
    localparam int unsigned SlotIW = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;
    localparam int unsigned AddrW  = 8 + YW + XW;

    localparam logic [CntW-1:0]  ScanLast = CntW'(NUM_SPRITE);
    localparam logic [XW:0]      XLast    = (XW+1)'(SPR_W);
    localparam logic [SlotW-1:0] SlotMax  = SlotW'(MAX_SLOT);

    typedef enum logic [1:0] {StIdle, StScan, StDraw, StDone} state_e;

    state_e state_q, state_d;

    logic [9:0]       target_q, target_d;
    logic [CntW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [SlotW-1:0] slot_cnt_q, slot_cnt_d;
    logic [SlotW-1:0] slot_idx_q, slot_idx_d;
    logic [XW:0]      x_q, x_d;
    logic             overflow_q, overflow_d;
    logic             slot_wr;

    logic start_acc, scan_eval, draw_active, draw_issue;

    // ------------------------------------------------------------------
    // Attribute store: enables live in resettable flops, the rest in plain RAM
    // ------------------------------------------------------------------
    logic [28:0]           attr_mem [NUM_SPRITE];
    logic [NUM_SPRITE-1:0] attr_en_q;
    logic [29:0]           attr_rd_q;
    logic [IdxW-1:0]       rd_idx;
    logic                  unused_rsvd;

    assign unused_rsvd = ^wr_data[28:27];
    assign rd_idx      = scan_cnt_q[IdxW-1:0];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            attr_mem[wr_idx] <= {wr_data[30:29], wr_data[26:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            attr_en_q <= '0;
        end else if (wr_en) begin
            attr_en_q[wr_idx] <= wr_data[31];
        end
    end

    always_ff @(posedge clk) begin
        attr_rd_q <= {attr_en_q[rd_idx], attr_mem[rd_idx]};
    end

    logic       at_en, at_hflip, at_vflip;
    logic [8:0] at_row;
    logic [9:0] at_col;
    logic [7:0] at_frame;
    logic [9:0] at_dy;
    logic       sc_hit;

    assign {at_en, at_hflip, at_vflip, at_row, at_col, at_frame} = attr_rd_q;
    // Rows below the target wrap to a large dy and therefore miss.
    assign at_dy  = target_q - {1'b0, at_row};
    assign sc_hit = scan_eval && at_en && (at_dy < 10'(SPR_H));

    // ------------------------------------------------------------------
    // Slot table
    // ------------------------------------------------------------------
    logic [YW-1:0] slot_dy_q    [MAX_SLOT];
    logic          slot_hflip_q [MAX_SLOT];
    logic          slot_vflip_q [MAX_SLOT];
    logic [9:0]    slot_col_q   [MAX_SLOT];
    logic [7:0]    slot_frame_q [MAX_SLOT];

    always_ff @(posedge clk) begin
        if (slot_wr) begin
            slot_dy_q[slot_cnt_q[SlotIW-1:0]]    <= at_dy[YW-1:0];
            slot_hflip_q[slot_cnt_q[SlotIW-1:0]] <= at_hflip;
            slot_vflip_q[slot_cnt_q[SlotIW-1:0]] <= at_vflip;
            slot_col_q[slot_cnt_q[SlotIW-1:0]]   <= at_col;
            slot_frame_q[slot_cnt_q[SlotIW-1:0]] <= at_frame;
        end
    end

    // ------------------------------------------------------------------
    // Draw address generation
    // ------------------------------------------------------------------
    logic [SlotIW-1:0] cur;
    logic [YW-1:0]     ro;
    logic [XW-1:0]     co;
    logic [AddrW-1:0]  addr_full;
    logic [10:0]       col_full;

    assign cur = slot_idx_q[SlotIW-1:0];
    // With power-of-two sizes, size-1-n is the bitwise complement of n.
    assign ro  = slot_vflip_q[cur] ? ~slot_dy_q[cur] : slot_dy_q[cur];
    assign co  = slot_hflip_q[cur] ? ~x_q[XW-1:0] : x_q[XW-1:0];

    assign addr_full = {slot_frame_q[cur], ro, co};
    assign col_full  = {1'b0, slot_col_q[cur]} + 11'(x_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (scan_cnt_q == ScanLast) begin
                    state_d = (slot_cnt_d != '0) ? StDraw : StDone;
                end
            end
            StDraw: begin
                if (x_q == XLast && slot_idx_q == slot_cnt_q - SlotW'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        start_acc   = (state_q == StIdle || state_q == StDone) && start;
        scan_eval   = (state_q == StScan) && (scan_cnt_q != '0);
        draw_active = (state_q == StDraw);
        draw_issue  = draw_active && (x_q != XLast);
        done        = (state_q == StDone) || (vcount >= 10'd479 && vcount < 10'd524);
    end

    // ------------------------------------------------------------------
    // Counters, slot bookkeeping, overflow
    // ------------------------------------------------------------------
    always_comb begin
        target_d   = target_q;
        scan_cnt_d = scan_cnt_q;
        slot_cnt_d = slot_cnt_q;
        slot_idx_d = slot_idx_q;
        x_d        = x_q;
        overflow_d = overflow_q;
        slot_wr    = 1'b0;
        if (start_acc) begin
            target_d   = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
            scan_cnt_d = '0;
            slot_cnt_d = '0;
            slot_idx_d = '0;
            x_d        = '0;
            overflow_d = 1'b0;
        end else begin
            if (state_q == StScan) begin
                scan_cnt_d = scan_cnt_q + CntW'(1);
                if (sc_hit) begin
                    if (slot_cnt_q < SlotMax) begin
                        slot_wr    = 1'b1;
                        slot_cnt_d = slot_cnt_q + SlotW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            if (draw_active) begin
                if (x_q == XLast) begin
                    x_d        = '0;
                    slot_idx_d = slot_idx_q + SlotW'(1);
                end else begin
                    x_d = x_q + (XW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q   <= '0;
            scan_cnt_q <= '0;
            slot_cnt_q <= '0;
            slot_idx_q <= '0;
            x_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            target_q   <= target_d;
            scan_cnt_q <= scan_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            slot_idx_q <= slot_idx_d;
            x_q        <= x_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: address cycle, then ROM data cycle aligned with pixel outputs
    // ------------------------------------------------------------------
    logic [15:0] rom_addr_q;
    logic        pend_valid_q;
    logic [10:0] pend_col_q;
    logic        pix_valid_q;
    logic [10:0] pix_col_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_col_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_col_q    <= '0;
        end else begin
            pend_valid_q <= draw_issue;
            if (draw_issue) begin
                rom_addr_q <= 16'(addr_full);
                pend_col_q <= col_full;
            end
            pix_valid_q <= pend_valid_q;
            pix_col_q   <= pend_col_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pixel_col  = pix_col_q[9:0];
    assign pixel_data = pix_valid_q ? rom_q : 16'h0000;
    assign pixel_wren = pix_valid_q && (pix_col_q <= 11'd639) && (rom_q != KEY_COLOR);
    assign overflow   = overflow_q;

endmodule
